// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_pkg
// Description : Shared definitions for the bit-serial adder: the controller
//               state encoding and the default operand width.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Combinational 1-bit full adder, the only arithmetic element
//               of the serial adder datapath.
// Ports       : a, b, ci - addend bits and carry-in
//               s, co    - sum bit and carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule
`default_nettype wire

// File: rtl/serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_adder_ctrl
// Description : Bit-serial adder. An accepted start captures op_a, op_b and
//               cin, then one bit per clock is added LSB first through a
//               single full adder. The result and carry-out are registered
//               on the last bit and held until the next completion.
// Ports       : clk, rst (sync, active-high)
//               start, op_a, op_b, cin  - request and operands
//               busy, done              - status (done is a 1-cycle pulse)
//               sum, cout, led          - result, carry-out, display
// Revision    : 1.0 - initial release
// ============================================================================
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic [4:0]       led
);

    // Counter holds 0..WIDTH, so it can never wrap while running.
    localparam int             CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_sh_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB; after WIDTH shifts bit 0 lands at the LSB.
    generate
        if (WIDTH == 1) begin : g_shift_1
            assign sum_sh_next = fa_s;
        end else begin : g_shift_n
            assign sum_sh_next = {fa_s, sum_sh[WIDTH-1:1]};
        end
    endgenerate

    // Size cast both truncates (WIDTH>4) and zero-extends (WIDTH<4).
    assign led = {cout, 4'(sum)};

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
            carry  <= 1'b0;
            cnt    <= '0;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= op_a;
                        b_sh  <= op_b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    sum_sh <= sum_sh_next;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    carry  <= fa_co;
                    cnt    <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        sum   <= sum_sh_next;
                        cout  <= fa_co;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_adder_ctrl
// Description : Self-checking bench for serial_adder_ctrl (WIDTH=4): directed
//               vector table, reset/abort and back-to-back sequences, and
//               randomized additions against an arithmetic reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_adder_ctrl;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic [4:0]   led;

    int checks   = 0;
    int failures = 0;
    int done_cnt = 0;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        bit           hold;
        logic [W-1:0] es;
        logic         ec;
        logic [4:0]   eled;
    } vec_t;

    vec_t tbl [7];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op_a  (op_a),
        .op_b  (op_b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout),
        .led   (led)
    );

    always #5 clk = ~clk;

    // Value of done seen at each edge = done level of the preceding cycle.
    always @(posedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One addition; returns edges from acceptance to done and the result.
    task automatic do_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                          input bit hold, input bit scramble,
                          output int lat, output logic busy_run,
                          output logic [W-1:0] s, output logic co, output logic [4:0] l,
                          output logic done_after, output logic busy_after);
        @(negedge clk);
        start = 1'b1; op_a = a; op_b = b; cin = c;
        @(negedge clk);
        busy_run = busy;
        if (!hold) start = 1'b0;
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (scramble) begin
                op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        s = sum; co = cout; l = led;
        start = 1'b0;
        @(negedge clk);
        done_after = done;
        busy_after = busy;
    endtask

    initial begin
        int           lat, n, gap, d0;
        logic         brun, da, ba, co;
        logic [W-1:0] s;
        logic [4:0]   l;
        int           ref_total;
        logic [W-1:0] ra, rb;
        logic         rc;

        tbl[0] = '{4'd5,  4'd3,  1'b0, 1'b0, 4'd8,  1'b0, 5'b01000};
        tbl[1] = '{4'd15, 4'd1,  1'b0, 1'b0, 4'd0,  1'b1, 5'b10000};
        tbl[2] = '{4'd15, 4'd15, 1'b1, 1'b1, 4'd15, 1'b1, 5'b11111};
        tbl[3] = '{4'd0,  4'd0,  1'b0, 1'b0, 4'd0,  1'b0, 5'b00000};
        tbl[4] = '{4'd0,  4'd0,  1'b1, 1'b0, 4'd1,  1'b0, 5'b00001};
        tbl[5] = '{4'd10, 4'd6,  1'b1, 1'b1, 4'd1,  1'b1, 5'b10001};
        tbl[6] = '{4'd9,  4'd4,  1'b0, 1'b0, 4'd13, 1'b0, 5'b01101};

        rst = 1'b1; start = 1'b0; op_a = '0; op_b = '0; cin = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 0);
        check("reset_done", 32'(done), 0);
        check("reset_sum",  32'(sum),  0);
        check("reset_cout", 32'(cout), 0);
        check("reset_led",  32'(led),  0);
        rst = 1'b0;

        // Directed vector table; hold=1 keeps start high through RUN.
        for (int i = 0; i < 7; i++) begin
            d0 = done_cnt;
            do_add(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].hold, 1'b0, lat, brun, s, co, l, da, ba);
            check($sformatf("vec%0d_latency", i), 32'(lat), W);
            check($sformatf("vec%0d_busy_run", i), 32'(brun), 1);
            check($sformatf("vec%0d_sum", i), 32'(s), 32'(tbl[i].es));
            check($sformatf("vec%0d_cout", i), 32'(co), 32'(tbl[i].ec));
            check($sformatf("vec%0d_led", i), 32'(l), 32'(tbl[i].eled));
            check($sformatf("vec%0d_done_pulse", i), 32'(da), 0);
            check($sformatf("vec%0d_idle_after", i), 32'(ba), 0);
            repeat (3) @(negedge clk);
            check($sformatf("vec%0d_one_done", i), 32'(done_cnt - d0), 1);
            check($sformatf("vec%0d_sum_held", i), 32'(sum), 32'(tbl[i].es));
        end

        // Reset priority over start.
        @(negedge clk);
        d0 = done_cnt;
        rst = 1'b1; start = 1'b1; op_a = 4'd1; op_b = 4'd1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("rst_prio_busy", 32'(busy), 0);
        repeat (6) @(negedge clk);
        check("rst_prio_no_done", 32'(done_cnt - d0), 0);

        // Abort mid-run: a previous result is visible, then reset clears it.
        do_add(4'd9, 4'd4, 1'b0, 1'b0, 1'b0, lat, brun, s, co, l, da, ba);
        check("pre_abort_sum", 32'(s), 13);
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1; op_a = 4'd9; op_b = 4'd6; cin = 1'b0;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_sum",  32'(sum),  0);
        check("abort_cout", 32'(cout), 0);
        repeat (6) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - d0), 0);
        check("abort_still_idle", 32'(busy), 0);
        do_add(4'd2, 4'd2, 1'b0, 1'b0, 1'b0, lat, brun, s, co, l, da, ba);
        check("post_abort_sum", 32'(s), 4);
        check("post_abort_latency", 32'(lat), W);

        // Back-to-back with start held high throughout.
        @(negedge clk);
        start = 1'b1; op_a = 4'd7; op_b = 4'd1; cin = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 30) begin
            @(negedge clk);
            n++;
        end
        check("b2b_first_sum", 32'(sum), 8);
        op_a = 4'd3; op_b = 4'd4;
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (done !== 1'b1 && gap < 30);
        start = 1'b0;
        check("b2b_gap", 32'(gap), W + 2);
        check("b2b_second_sum", 32'(sum), 7);
        check("b2b_second_cout", 32'(cout), 0);
        repeat (3) @(negedge clk);

        // Random additions, operands scrambled while running.
        for (int i = 0; i < 40; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            ref_total = int'(ra) + int'(rb) + int'(rc);
            do_add(ra, rb, rc, 1'($urandom), 1'b1, lat, brun, s, co, l, da, ba);
            check($sformatf("rnd%0d_latency", i), 32'(lat), W);
            check($sformatf("rnd%0d_sum", i), 32'(s), 32'(ref_total % (1 << W)));
            check($sformatf("rnd%0d_cout", i), 32'(co), 32'(ref_total / (1 << W)));
            check($sformatf("rnd%0d_led", i), 32'(l),
                  32'(((ref_total / (1 << W)) << 4) | (ref_total % 16)));
            check($sformatf("rnd%0d_done_pulse", i), 32'(da), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_adder_ctrl.md
SERIAL_ADDER_CTRL -- requirements
Module: serial_adder_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, sets the operand and result width in bits; legal range is 1..16.
REQ-002 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 Port start, input, 1 bit: request to begin an addition; sampled at each rising edge.
REQ-005 Port op_a, input, WIDTH bits: addend A; sampled only when start is accepted.
REQ-006 Port op_b, input, WIDTH bits: addend B; sampled only when start is accepted.
REQ-007 Port cin, input, 1 bit: carry-in; sampled only when start is accepted.
REQ-008 Port busy, output, 1 bit: high whenever the block is not in IDLE.
REQ-009 Port done, output, 1 bit: one-cycle completion pulse.
REQ-010 Port sum, output, WIDTH bits: registered result of the last completed addition.
REQ-011 Port cout, output, 1 bit: registered carry-out of the last completed addition.
REQ-012 Port led, output, 5 bits: board display; led[3:0] = sum[3:0], zero-extended when WIDTH<4; led[4] = cout.

Function
REQ-013 The block SHALL be a three-state FSM with states IDLE, RUN and DONE.
REQ-014 IDLE with start=1 at an edge:
- op_a and op_b load into shift registers a_sh and b_sh;
- cin loads into the carry register;
- the bit counter clears to 0;
- the state goes to RUN.
REQ-015 IDLE with start=0: the block SHALL hold all registers.
REQ-016 RUN, each edge, processes one bit through one 1-bit full adder, LSB first:
- the adder inputs are a_sh[0], b_sh[0] and carry;
- the sum bit shifts into the MSB of sum_sh;
- a_sh and b_sh shift right;
- carry takes the adder carry-out;
- the counter increments.
REQ-017 RUN, at the edge processing bit WIDTH-1:
- sum takes the final sum_sh value;
- cout takes the final carry;
- the state goes to DONE.
REQ-018 DONE: done=1 for exactly that one cycle, and the next edge SHALL return the state to IDLE.
REQ-019 Latency: if start is accepted at edge E0, done SHALL be high in the cycle following edge E(WIDTH), i.e. WIDTH+1 edges after acceptance.
REQ-020 start while busy=1 (RUN or DONE) SHALL be ignored; an accepted start in IDLE the cycle after done gives back-to-back throughput of one result per WIDTH+2 cycles.
REQ-021 Changes on op_a, op_b or cin after acceptance SHALL NOT affect the result in progress.
REQ-022 sum and cout SHALL hold their value from the previous completion until the next completion.
REQ-023 Arithmetic: {cout,sum} = op_a + op_b + cin, modulo 2^(WIDTH+1), with no overflow flag other than cout.
REQ-024 The bit counter SHALL be ceil(log2(WIDTH+1)) bits wide and never wrap during RUN.

Reset
REQ-025 rst=1 at an edge SHALL force:
- state to IDLE;
- busy=0, done=0;
- sum=0, cout=0, led=0;
- carry, counter and all shift registers to 0.
REQ-026 rst during RUN or DONE SHALL abort the operation with no done pulse, and sum/cout SHALL read 0 afterward.
REQ-027 rst has priority over start in the same cycle.

Structure
REQ-028 A shared package serial_adder_pkg SHALL hold:
- the state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2;
- the default WIDTH constant.
REQ-029 The 1-bit adder SHALL be a separate combinational sub-module full_adder (ports a, b, ci, s, co), instantiated once.
REQ-030 Expected RTL size SHALL be 120-400 lines, with no memories and no multi-bit adders outside full_adder.

Verification
REQ-031 WIDTH=4; op_a=5, op_b=3, cin=0, start pulsed at E0 -> done high after E4 only; sum=8, cout=0, led=5'b01000.
REQ-032 WIDTH=4; op_a=15, op_b=1, cin=0 -> sum=0, cout=1, led=5'b10000.
REQ-033 WIDTH=4; op_a=15, op_b=15, cin=1 -> sum=15, cout=1; start re-pulsed in RUN and DONE is ignored, with exactly one done pulse.
REQ-034 Start 9+6 with cin=0, assert rst one cycle after E2 -> no done pulse; busy=0, sum=0, cout=0; a new start 2+2 then yields sum=4.
REQ-035 Back-to-back: 7+1 completes (sum=8), start held high through done, 3+4 accepted in IDLE -> second done exactly WIDTH+2 cycles after the first, with sum=7.
REQ-036 op_a/op_b toggled randomly during RUN -> result equals the values sampled at acceptance.
